// File: rtl/axi_protocol_checker.sv
// axi_protocol_checker
// Passive AXI4 protocol monitor. Observes all five channels of one AXI
// link and raises sticky error flags for the following violations:
//   err_flags[0] AW payload changed or VALID dropped while stalled
//   err_flags[1] W  payload changed or VALID dropped while stalled
//   err_flags[2] AR payload changed or VALID dropped while stalled
//   err_flags[3] WLAST does not match the burst length of the head AW
//   err_flags[4] tracking overflow/underflow (W without AW, AW FIFO full,
//                too many outstanding reads); the offending item is dropped
//   err_flags[5] B response with no write awaiting a response
//   err_flags[6] R beat with no read outstanding
//   err_flags[7] some channel stalled (VALID && !READY) too long
// Ports:
//   AXI_ACLK, AXI_ARESET_N       clock, asynchronous active-low reset
//   AXI_AW*/W*/B*/AR*/R*         observed AXI channel signals (all inputs)
//   has_checks                   0 = flags never set, tracking continues
//   err_clr                      synchronous clear of all flags (wins over set)
//   err_flags[7:0], err_irq      sticky flags and their OR
//   wr_outstanding               AW FIFO occupancy + writes awaiting B
//   rd_outstanding               read bursts awaiting RLAST
module axi_protocol_checker #(
    parameter int C_AXI_ID_WIDTH    = 10,
    parameter int C_AXI_ADDR_WIDTH  = 32,
    parameter int C_AXI_DATA_WIDTH  = 32,
    parameter int C_AXI_LEN_WIDTH   = 8,
    parameter int C_MAX_OUTSTANDING = 8,
    parameter int C_TIMEOUT_CYCLES  = 256,
    localparam int STRB_W = C_AXI_DATA_WIDTH / 8,
    localparam int OUT_W  = $clog2(C_MAX_OUTSTANDING + 1)
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESET_N,
    input  logic [C_AXI_ID_WIDTH-1:0]   AXI_AWID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR,
    input  logic [C_AXI_LEN_WIDTH-1:0]  AXI_AWLEN,
    input  logic                        AXI_AWVALID,
    input  logic                        AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] AXI_WDATA,
    input  logic [STRB_W-1:0]           AXI_WSTRB,
    input  logic                        AXI_WLAST,
    input  logic                        AXI_WVALID,
    input  logic                        AXI_WREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   AXI_BID,
    input  logic [1:0]                  AXI_BRESP,
    input  logic                        AXI_BVALID,
    input  logic                        AXI_BREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   AXI_ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
    input  logic [C_AXI_LEN_WIDTH-1:0]  AXI_ARLEN,
    input  logic                        AXI_ARVALID,
    input  logic                        AXI_ARREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   AXI_RID,
    input  logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA,
    input  logic [1:0]                  AXI_RRESP,
    input  logic                        AXI_RLAST,
    input  logic                        AXI_RVALID,
    input  logic                        AXI_RREADY,
    input  logic                        has_checks,
    input  logic                        err_clr,
    output logic [7:0]                  err_flags,
    output logic                        err_irq,
    output logic [OUT_W-1:0]            wr_outstanding,
    output logic [OUT_W-1:0]            rd_outstanding
);

    localparam int PTR_W = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;
    localparam int TO_W  = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam int AP_W  = C_AXI_ID_WIDTH + C_AXI_ADDR_WIDTH + C_AXI_LEN_WIDTH;
    localparam int WP_W  = C_AXI_DATA_WIDTH + STRB_W + 1;

    localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(C_MAX_OUTSTANDING);
    localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(C_TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_PRE  = TO_W'(C_TIMEOUT_CYCLES - 1);

    // Response IDs/data are not checked; fold them so they count as used.
    logic unused_inputs_s;
    assign unused_inputs_s = ^{AXI_BID, AXI_BRESP, AXI_RID, AXI_RDATA, AXI_RRESP};

    // Handshakes and current payloads
    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic [AP_W-1:0] aw_pay_s, ar_pay_s;
    logic [WP_W-1:0] w_pay_s;
    assign aw_hs_s  = AXI_AWVALID & AXI_AWREADY;
    assign w_hs_s   = AXI_WVALID  & AXI_WREADY;
    assign b_hs_s   = AXI_BVALID  & AXI_BREADY;
    assign ar_hs_s  = AXI_ARVALID & AXI_ARREADY;
    assign r_hs_s   = AXI_RVALID  & AXI_RREADY;
    assign aw_pay_s = {AXI_AWID, AXI_AWADDR, AXI_AWLEN};
    assign ar_pay_s = {AXI_ARID, AXI_ARADDR, AXI_ARLEN};
    assign w_pay_s  = {AXI_WDATA, AXI_WSTRB, AXI_WLAST};

    // State
    logic                       aw_stall_q, w_stall_q, ar_stall_q;
    logic [AP_W-1:0]            aw_pay_q, ar_pay_q;
    logic [WP_W-1:0]            w_pay_q;
    logic [C_AXI_LEN_WIDTH-1:0] fifo_mem_q [C_MAX_OUTSTANDING];
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [OUT_W-1:0]           fifo_cnt_q, fifo_cnt_d;
    logic [C_AXI_LEN_WIDTH-1:0] beat_q, beat_d;
    logic [OUT_W-1:0]           b_pend_q, b_pend_d;
    logic [OUT_W-1:0]           rd_cnt_q, rd_cnt_d;
    logic [OUT_W-1:0]           wr_out_q, wr_out_d;
    logic [4:0][TO_W-1:0]       to_q, to_d;
    logic [7:0]                 err_q, err_d;
    logic                       irq_q;

    // Combinational helpers
    logic                       fifo_empty_s, fifo_full_s, has_head_s, last_idx_s;
    logic                       w_beat_s, pop_s, push_s, rlast_hs_s;
    logic                       rd_inc_s, rd_dec_s, b_dec_s;
    logic [C_AXI_LEN_WIDTH-1:0] head_len_s;
    logic [4:0]                 chan_stall_s, to_hit_s;
    logic [7:0]                 viol_s;
    logic [OUT_W:0]             wr_sum_s;

    assign chan_stall_s = {AXI_RVALID  & ~AXI_RREADY,
                           AXI_ARVALID & ~AXI_ARREADY,
                           AXI_BVALID  & ~AXI_BREADY,
                           AXI_WVALID  & ~AXI_WREADY,
                           AXI_AWVALID & ~AXI_AWREADY};

    // Burst tracking decisions: FIFO head (with empty-FIFO AW bypass), push/pop, counters
    always_comb begin
        fifo_empty_s = (fifo_cnt_q == '0);
        fifo_full_s  = (fifo_cnt_q == MAX_CNT);
        has_head_s   = !fifo_empty_s || aw_hs_s;
        // An AW arriving into an empty FIFO governs a same-cycle W beat.
        if (fifo_empty_s) begin
            head_len_s = AXI_AWLEN;
        end else begin
            head_len_s = fifo_mem_q[rd_ptr_q];
        end
        last_idx_s = (beat_q == head_len_s);
        w_beat_s   = w_hs_s && has_head_s;
        pop_s      = w_beat_s && last_idx_s;
        // A full FIFO still accepts an AW when the head pops in the same cycle.
        push_s     = aw_hs_s && (!fifo_full_s || pop_s);
        rlast_hs_s = r_hs_s && AXI_RLAST;
        rd_dec_s   = rlast_hs_s && (rd_cnt_q != '0);
        rd_inc_s   = ar_hs_s && ((rd_cnt_q != MAX_CNT) || rd_dec_s);
        b_dec_s    = b_hs_s && (b_pend_q != '0);
    end

    // Next-state for counters, timeouts and the wr_outstanding sum
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        beat_d     = beat_q;
        b_pend_d   = b_pend_q;
        rd_cnt_d   = rd_cnt_q;
        to_d       = to_q;
        to_hit_s   = 5'b00000;

        if (push_s && !pop_s) begin
            fifo_cnt_d = fifo_cnt_q + OUT_W'(1);
        end else if (pop_s && !push_s) begin
            fifo_cnt_d = fifo_cnt_q - OUT_W'(1);
        end else begin
            fifo_cnt_d = fifo_cnt_q;
        end

        if (pop_s) begin
            beat_d = '0;
        end else if (w_beat_s) begin
            beat_d = beat_q + C_AXI_LEN_WIDTH'(1);
        end else begin
            beat_d = beat_q;
        end

        // b_pending saturates rather than wrapping when responses never arrive.
        if (pop_s && !b_dec_s) begin
            if (b_pend_q != '1) begin
                b_pend_d = b_pend_q + OUT_W'(1);
            end else begin
                b_pend_d = b_pend_q;
            end
        end else if (b_dec_s && !pop_s) begin
            b_pend_d = b_pend_q - OUT_W'(1);
        end else begin
            b_pend_d = b_pend_q;
        end

        if (rd_inc_s && !rd_dec_s) begin
            rd_cnt_d = rd_cnt_q + OUT_W'(1);
        end else if (rd_dec_s && !rd_inc_s) begin
            rd_cnt_d = rd_cnt_q - OUT_W'(1);
        end else begin
            rd_cnt_d = rd_cnt_q;
        end

        // The hit fires on the stalled cycle that brings the count to the limit.
        for (int i = 0; i < 5; i++) begin
            if (chan_stall_s[i]) begin
                if (to_q[i] != TO_LIM) begin
                    to_d[i] = to_q[i] + TO_W'(1);
                end else begin
                    to_d[i] = to_q[i];
                end
                to_hit_s[i] = (to_q[i] >= TO_PRE);
            end else begin
                to_d[i]     = '0;
                to_hit_s[i] = 1'b0;
            end
        end

        wr_sum_s = {1'b0, fifo_cnt_d} + {1'b0, b_pend_d};
        if (wr_sum_s[OUT_W]) begin
            wr_out_d = '1;
        end else begin
            wr_out_d = wr_sum_s[OUT_W-1:0];
        end
    end

    // Violation detection and sticky flag update (clear has priority)
    always_comb begin
        viol_s    = 8'h00;
        viol_s[0] = aw_stall_q && (!AXI_AWVALID || (aw_pay_s != aw_pay_q));
        viol_s[1] = w_stall_q  && (!AXI_WVALID  || (w_pay_s  != w_pay_q));
        viol_s[2] = ar_stall_q && (!AXI_ARVALID || (ar_pay_s != ar_pay_q));
        viol_s[3] = w_beat_s && (AXI_WLAST != last_idx_s);
        viol_s[4] = (w_hs_s && !has_head_s)
                  || (aw_hs_s && fifo_full_s && !pop_s)
                  || (ar_hs_s && (rd_cnt_q == MAX_CNT) && !rlast_hs_s);
        viol_s[5] = b_hs_s && (b_pend_q == '0);
        viol_s[6] = r_hs_s && (rd_cnt_q == '0);
        viol_s[7] = |to_hit_s;
        if (err_clr) begin
            err_d = 8'h00;
        end else if (has_checks) begin
            err_d = err_q | viol_s;
        end else begin
            err_d = err_q;
        end
    end

    // Stall capture registers: remember whether each request channel was stalled and its payload
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
        if (!AXI_ARESET_N) begin
            aw_stall_q <= 1'b0;
            w_stall_q  <= 1'b0;
            ar_stall_q <= 1'b0;
            aw_pay_q   <= '0;
            w_pay_q    <= '0;
            ar_pay_q   <= '0;
        end else begin
            aw_stall_q <= AXI_AWVALID & ~AXI_AWREADY;
            w_stall_q  <= AXI_WVALID  & ~AXI_WREADY;
            ar_stall_q <= AXI_ARVALID & ~AXI_ARREADY;
            aw_pay_q   <= aw_pay_s;
            w_pay_q    <= w_pay_s;
            ar_pay_q   <= ar_pay_s;
        end
    end

    // AW length FIFO storage and pointers
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
        if (!AXI_ARESET_N) begin
            for (int i = 0; i < C_MAX_OUTSTANDING; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= AXI_AWLEN;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Tracking counters, timeout counters, flags and registered outputs
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
        if (!AXI_ARESET_N) begin
            fifo_cnt_q <= '0;
            beat_q     <= '0;
            b_pend_q   <= '0;
            rd_cnt_q   <= '0;
            wr_out_q   <= '0;
            to_q       <= '0;
            err_q      <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            beat_q     <= beat_d;
            b_pend_q   <= b_pend_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_out_q   <= wr_out_d;
            to_q       <= to_d;
            err_q      <= err_d;
            irq_q      <= |err_d;
        end
    end

    assign err_flags      = err_q;
    assign err_irq        = irq_q;
    assign wr_outstanding = wr_out_q;
    assign rd_outstanding = rd_cnt_q;

endmodule

// File: tb/tb_axi_protocol_checker.sv
// Bench for axi_protocol_checker: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// queue-based behavioural model of the checker's rules.
module tb_axi_protocol_checker;

    localparam int IDW  = 10;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LW   = 8;
    localparam int MAXO = 8;
    localparam int TO   = 256;
    localparam int SW   = DW / 8;
    localparam int OW   = $clog2(MAXO + 1);
    localparam int OMAX = (1 << OW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IDW-1:0] awid, bid, arid, rid;
    logic [AW-1:0]  awaddr, araddr;
    logic [LW-1:0]  awlen, arlen;
    logic [DW-1:0]  wdata, rdata;
    logic [SW-1:0]  wstrb;
    logic [1:0]     bresp, rresp;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic has_checks, err_clr;
    logic [7:0]     err_flags;
    logic           err_irq;
    logic [OW-1:0]  wr_out, rd_out;

    axi_protocol_checker #(
        .C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW),
        .C_AXI_LEN_WIDTH(LW), .C_MAX_OUTSTANDING(MAXO), .C_TIMEOUT_CYCLES(TO)
    ) dut (
        .AXI_ACLK(clk), .AXI_ARESET_N(rst_n),
        .AXI_AWID(awid), .AXI_AWADDR(awaddr), .AXI_AWLEN(awlen),
        .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WLAST(wlast),
        .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BID(bid), .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARID(arid), .AXI_ARADDR(araddr), .AXI_ARLEN(arlen),
        .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RID(rid), .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RLAST(rlast),
        .AXI_RVALID(rvalid), .AXI_RREADY(rready),
        .has_checks(has_checks), .err_clr(err_clr),
        .err_flags(err_flags), .err_irq(err_irq),
        .wr_outstanding(wr_out), .rd_outstanding(rd_out)
    );

    // Behavioural model state
    int          mq[$];
    int          m_beat, m_bpend, m_rd;
    int          m_to[5];
    logic [7:0]  m_flags;
    bit          m_aw_st, m_w_st, m_ar_st;
    logic [IDW+AW+LW-1:0] m_aw_p, m_ar_p;
    logic [DW+SW:0]       m_w_p;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_beat = 0; m_bpend = 0; m_rd = 0;
        for (int i = 0; i < 5; i++) m_to[i] = 0;
        m_flags = 8'h00;
        m_aw_st = 1'b0; m_w_st = 1'b0; m_ar_st = 1'b0;
        m_aw_p = '0; m_ar_p = '0; m_w_p = '0;
    endtask

    // Apply the checker's rules to the inputs present at this rising edge.
    task automatic model_step();
        logic [7:0] v;
        bit awh, wh, bh, arh, rh, rlh, has_head, pop, bdec, rdec, rinc;
        bit vv[5];
        bit rr[5];
        int hl;
        v   = 8'h00;
        awh = awvalid && awready;
        wh  = wvalid && wready;
        bh  = bvalid && bready;
        arh = arvalid && arready;
        rh  = rvalid && rready;
        v[0] = m_aw_st && (!awvalid || ({awid, awaddr, awlen} != m_aw_p));
        v[1] = m_w_st  && (!wvalid  || ({wdata, wstrb, wlast} != m_w_p));
        v[2] = m_ar_st && (!arvalid || ({arid, araddr, arlen} != m_ar_p));
        m_aw_st = awvalid && !awready; m_aw_p = {awid, awaddr, awlen};
        m_w_st  = wvalid && !wready;   m_w_p  = {wdata, wstrb, wlast};
        m_ar_st = arvalid && !arready; m_ar_p = {arid, araddr, arlen};

        has_head = (mq.size() > 0) || awh;
        hl       = (mq.size() > 0) ? mq[0] : int'(awlen);
        pop      = wh && has_head && (m_beat == hl);
        v[3]     = wh && has_head && (wlast != (m_beat == hl));
        rlh      = rh && rlast;
        v[4]     = (wh && !has_head) || (awh && mq.size() == MAXO && !pop)
                 || (arh && m_rd == MAXO && !rlh);
        v[5]     = bh && (m_bpend == 0);
        v[6]     = rh && (m_rd == 0);

        if (awh && (mq.size() < MAXO || pop)) mq.push_back(int'(awlen));
        if (pop) begin
            void'(mq.pop_front());
            m_beat = 0;
        end else if (wh && has_head) begin
            m_beat++;
        end

        bdec    = bh && (m_bpend > 0);
        m_bpend = m_bpend + (pop ? 1 : 0) - (bdec ? 1 : 0);
        if (m_bpend > OMAX) m_bpend = OMAX;

        rdec = rlh && (m_rd > 0);
        rinc = arh && ((m_rd < MAXO) || rdec);
        m_rd = m_rd + (rinc ? 1 : 0) - (rdec ? 1 : 0);

        vv = '{awvalid, wvalid, bvalid, arvalid, rvalid};
        rr = '{awready, wready, bready, arready, rready};
        for (int i = 0; i < 5; i++) begin
            if (vv[i] && !rr[i]) begin
                if (m_to[i] < TO) m_to[i]++;
                if (m_to[i] >= TO) v[7] = 1'b1;
            end else begin
                m_to[i] = 0;
            end
        end

        if (err_clr) m_flags = 8'h00;
        else if (has_checks) m_flags = m_flags | v;
    endtask

    task automatic compare();
        int wexp;
        wexp = mq.size() + m_bpend;
        if (wexp > OMAX) wexp = OMAX;
        check("err_flags", err_flags, m_flags);
        check("err_irq", err_irq, |m_flags);
        check("wr_outstanding", wr_out, wexp);
        check("rd_outstanding", rd_out, m_rd);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic idle();
        awvalid = 1'b0; awready = 1'b0; awid = '0; awaddr = '0; awlen = '0;
        wvalid = 1'b0; wready = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        bvalid = 1'b0; bready = 1'b0; bid = '0; bresp = '0;
        arvalid = 1'b0; arready = 1'b0; arid = '0; araddr = '0; arlen = '0;
        rvalid = 1'b0; rready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_flags", err_flags, 32'd0);
        check("rst_wr", wr_out, 32'd0);
        compare();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_random(input int c);
        int wdiv;
        wdiv = ((c / 500) % 2 == 1) ? 4 : 1;
        if (!(awvalid && !awready) || $urandom_range(0, 15) == 0) begin
            awvalid = 1'($urandom_range(0, 2) == 0);
            awid = IDW'($urandom); awaddr = AW'($urandom); awlen = LW'($urandom_range(0, 3));
        end
        awready = 1'($urandom_range(0, 1));
        if (!(wvalid && !wready) || $urandom_range(0, 15) == 0) begin
            wvalid = 1'($urandom_range(0, wdiv) == 0);
            wdata = DW'($urandom); wstrb = SW'($urandom);
            if (mq.size() > 0) wlast = (m_beat == mq[0]);
            else wlast = (awlen == '0);
            if ($urandom_range(0, 19) == 0) wlast = ~wlast;
        end
        wready = 1'($urandom_range(0, 1));
        if (!(arvalid && !arready) || $urandom_range(0, 15) == 0) begin
            arvalid = 1'($urandom_range(0, 2) == 0);
            arid = IDW'($urandom); araddr = AW'($urandom); arlen = LW'($urandom_range(0, 3));
        end
        arready = 1'($urandom_range(0, 1));
        bvalid = (m_bpend > 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 30) == 0);
        bready = 1'($urandom_range(0, 1));
        bid = IDW'($urandom); bresp = 2'($urandom);
        rvalid = (m_rd > 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 30) == 0);
        rready = 1'($urandom_range(0, 1));
        rlast = 1'($urandom_range(0, 1));
        rid = IDW'($urandom); rdata = DW'($urandom); rresp = 2'($urandom);
        err_clr = 1'($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 299) == 0) has_checks = ~has_checks;
    endtask

    initial begin
        has_checks = 1'b1;
        idle();
        do_reset();

        // Legal write: AW LEN=3, four beats, one B
        awvalid = 1'b1; awready = 1'b1; awlen = 8'd3; awid = 10'd5; awaddr = 32'h40;
        cycle();
        check("wr_after_aw", wr_out, 32'd1);
        idle();
        wvalid = 1'b1; wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wlast = (i == 3); wdata = DW'(i);
            cycle();
        end
        idle();
        check("wr_before_b", wr_out, 32'd1);
        bvalid = 1'b1; bready = 1'b1;
        cycle();
        idle();
        check("wr_after_b", wr_out, 32'd0);
        check("legal_flags", err_flags, 32'd0);

        // Early WLAST, then clear
        do_reset();
        awvalid = 1'b1; awready = 1'b1; awlen = 8'd3;
        cycle();
        idle();
        wvalid = 1'b1; wready = 1'b1; wlast = 1'b0;
        cycle();
        wlast = 1'b1;
        cycle();
        idle();
        check("wlast_flag", err_flags, 32'h08);
        check("wlast_irq", err_irq, 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("clr_flags", err_flags, 32'd0);
        check("clr_irq", err_irq, 32'd0);

        // AR address changes while stalled
        do_reset();
        arvalid = 1'b1; arready = 1'b0; araddr = 32'h100;
        cycle();
        araddr = 32'h104;
        cycle();
        check("ar_stable", err_flags, 32'h04);
        arready = 1'b1;
        cycle();
        idle();
        check("ar_rd1", rd_out, 32'd1);

        // Read outstanding overflow, drain, then underflow
        do_reset();
        arvalid = 1'b1; arready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            araddr = AW'(i * 4);
            cycle();
        end
        idle();
        check("rd_ovf_flag", err_flags, 32'h10);
        check("rd_ovf_cnt", rd_out, 32'd8);
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        repeat (8) cycle();
        check("rd_drained", rd_out, 32'd0);
        cycle();
        idle();
        check("rd_unf_flag", err_flags, 32'h50);

        // W timeout, with and without checks
        do_reset();
        wvalid = 1'b1; wready = 1'b0; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        repeat (255) cycle();
        check("to_before", err_flags, 32'd0);
        cycle();
        check("to_hit", err_flags, 32'h80);
        do_reset();
        has_checks = 1'b0;
        wvalid = 1'b1; wready = 1'b0;
        repeat (300) cycle();
        check("to_nochecks", err_flags, 32'd0);
        do_reset();
        has_checks = 1'b1;

        // Same-cycle AW LEN=0 and W WLAST into empty FIFO
        awvalid = 1'b1; awready = 1'b1; awlen = 8'd0;
        wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
        cycle();
        idle();
        check("bypass_flags", err_flags, 32'd0);
        check("bypass_wr", wr_out, 32'd1);

        // Reset mid-burst discards tracking
        do_reset();
        awvalid = 1'b1; awready = 1'b1; awlen = 8'd3;
        cycle();
        idle();
        wvalid = 1'b1; wready = 1'b1; wlast = 1'b0;
        repeat (2) cycle();
        do_reset();
        wvalid = 1'b1; wready = 1'b1; wlast = 1'b0;
        cycle();
        idle();
        check("post_rst_w", err_flags, 32'h10);
        check("post_rst_wr", wr_out, 32'd0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            drive_random(c);
            cycle();
            if ($urandom_range(0, 1499) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
